// File: rtl/midi_pkg.sv
// Shared MIDI constants, message classification and byte-masking helper
// for the voice allocator.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF         = 4'h8;
    localparam logic [3:0] NOTE_ON          = 4'h9;
    localparam logic [3:0] CTRL             = 4'hB;
    localparam logic [7:0] CC_ALL_NOTES_OFF = 8'd123;

    typedef enum logic [1:0] {
        MSG_NONE = 2'd0,
        MSG_ON   = 2'd1,
        MSG_OFF  = 2'd2,
        MSG_ANO  = 2'd3
    } msg_kind_e;

    function automatic logic [7:0] mask7(input logic [7:0] b);
        return b & 8'h7F;
    endfunction

endpackage

// File: rtl/midi_voice_allocator_voice_select.sv
// Combinational voice search: voice already holding the incoming note,
// lowest-index free voice, and the oldest voice (highest age rank).
module voice_select #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_VOICES-1:0]       gate,
    input  logic [NUM_VOICES*IDX_W-1:0] rank,
    input  logic [NUM_VOICES*8-1:0]     note,
    input  logic [7:0]                  in_note,
    output logic [IDX_W-1:0]            match_idx,
    output logic                        match_vld,
    output logic [IDX_W-1:0]            free_idx,
    output logic                        free_vld,
    output logic [IDX_W-1:0]            old_idx,
    output logic                        old_vld
);

    logic hit_s;
    logic is_old_s;

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        match_idx = '0;
        match_vld = 1'b0;
        free_idx  = '0;
        free_vld  = 1'b0;
        old_idx   = '0;
        old_vld   = 1'b0;
        hit_s     = 1'b0;
        is_old_s  = 1'b0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            hit_s     = gate[v] && (note[8*v +: 8] == in_note);
            match_idx = hit_s ? IDX_W'(v) : match_idx;
            match_vld = match_vld | hit_s;
            free_idx  = !gate[v] ? IDX_W'(v) : free_idx;
            free_vld  = free_vld | !gate[v];
            is_old_s  = (rank[IDX_W*v +: IDX_W] == IDX_W'(NUM_VOICES - 1));
            old_idx   = is_old_s ? IDX_W'(v) : old_idx;
            old_vld   = old_vld | is_old_s;
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic MIDI voice allocator: note-on/off and all-notes-off handling
// with retrigger, lowest-free assignment and oldest-voice stealing.
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int MIDI_CH    = 0,
    parameter int OMNI       = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [23:0]             MIDI_MSG,
    input  logic                    MIDI_MSG_RDY,
    output logic [8*NUM_VOICES-1:0] VOICE_NOTE,
    output logic [8*NUM_VOICES-1:0] VOICE_VEL,
    output logic [NUM_VOICES-1:0]   VOICE_GATE,
    output logic [NUM_VOICES-1:0]   VOICE_TRIG,
    output logic [4:0]              ACTIVE_COUNT
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    logic [8*NUM_VOICES-1:0]     note_q, note_d;
    logic [8*NUM_VOICES-1:0]     vel_q, vel_d;
    logic [NUM_VOICES-1:0]       gate_q, gate_d;
    logic [NUM_VOICES-1:0]       trig_q, trig_d;
    logic [NUM_VOICES*IDX_W-1:0] rank_q, rank_d;
    logic [4:0]                  cnt_q, cnt_d;

    logic [7:0]       status_s;
    logic [7:0]       d1_s;
    logic [7:0]       d2_s;
    logic             ch_ok_s;
    msg_kind_e        kind_s;

    logic [IDX_W-1:0] match_idx_s, free_idx_s, old_idx_s, sel_s;
    logic             match_vld_s, free_vld_s, old_vld_s, sel_vld_s;
    logic [IDX_W-1:0] old_rank_s;

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_voice_select (
        .gate      (gate_q),
        .rank      (rank_q),
        .note      (note_q),
        .in_note   (d1_s),
        .match_idx (match_idx_s),
        .match_vld (match_vld_s),
        .free_idx  (free_idx_s),
        .free_vld  (free_vld_s),
        .old_idx   (old_idx_s),
        .old_vld   (old_vld_s)
    );

    // Classify the incoming message; a zero-velocity note-on counts as note-off.
    always_comb begin
        status_s = MIDI_MSG[23:16];
        d1_s     = mask7(MIDI_MSG[15:8]);
        d2_s     = mask7(MIDI_MSG[7:0]);
        ch_ok_s  = (OMNI != 0) || (status_s[3:0] == 4'(MIDI_CH));
        kind_s   = MSG_NONE;
        if (MIDI_MSG_RDY && ch_ok_s) begin
            case (status_s[7:4])
                NOTE_ON:  kind_s = (d2_s != 8'd0) ? MSG_ON : MSG_OFF;
                NOTE_OFF: kind_s = MSG_OFF;
                CTRL:     kind_s = (d1_s == CC_ALL_NOTES_OFF) ? MSG_ANO : MSG_NONE;
                default:  kind_s = MSG_NONE;
            endcase
        end else begin
            kind_s = MSG_NONE;
        end
    end

    // Next voice state: retrigger beats free voice, free voice beats stealing.
    always_comb begin
        note_d     = note_q;
        vel_d      = vel_q;
        gate_d     = gate_q;
        trig_d     = '0;
        rank_d     = rank_q;
        cnt_d      = 5'd0;
        sel_s      = match_vld_s ? match_idx_s : (free_vld_s ? free_idx_s : old_idx_s);
        sel_vld_s  = match_vld_s | free_vld_s | old_vld_s;
        old_rank_s = rank_q[IDX_W*sel_s +: IDX_W];
        case (kind_s)
            MSG_ON: begin
                if (sel_vld_s) begin
                    note_d[8*sel_s +: 8] = d1_s;
                    vel_d[8*sel_s +: 8]  = d2_s;
                    gate_d[sel_s]        = 1'b1;
                    trig_d[sel_s]        = 1'b1;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IDX_W'(v) == sel_s) begin
                            rank_d[IDX_W*v +: IDX_W] = '0;
                        end else if (rank_q[IDX_W*v +: IDX_W] < old_rank_s) begin
                            rank_d[IDX_W*v +: IDX_W] = rank_q[IDX_W*v +: IDX_W] + IDX_W'(1);
                        end else begin
                            rank_d[IDX_W*v +: IDX_W] = rank_q[IDX_W*v +: IDX_W];
                        end
                    end
                end else begin
                    trig_d = '0;
                end
            end
            MSG_OFF: begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    gate_d[v] = gate_q[v] & (note_q[8*v +: 8] != d1_s);
                end
            end
            MSG_ANO: begin
                gate_d = '0;
            end
            default: begin
                gate_d = gate_q;
            end
        endcase
        for (int v = 0; v < NUM_VOICES; v++) begin
            cnt_d = cnt_d + 5'(gate_d[v]);
        end
    end

    // State registers; reset restores the power-on age order (voice v has rank v).
    always_ff @(posedge CLK) begin
        if (RST) begin
            note_q <= '0;
            vel_q  <= '0;
            gate_q <= '0;
            trig_q <= '0;
            cnt_q  <= 5'd0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                rank_q[IDX_W*v +: IDX_W] <= IDX_W'(v);
            end
        end else begin
            note_q <= note_d;
            vel_q  <= vel_d;
            gate_q <= gate_d;
            trig_q <= trig_d;
            cnt_q  <= cnt_d;
            rank_q <= rank_d;
        end
    end

    assign VOICE_NOTE   = note_q;
    assign VOICE_VEL    = vel_q;
    assign VOICE_GATE   = gate_q;
    assign VOICE_TRIG   = trig_q;
    assign ACTIVE_COUNT = cnt_q;

endmodule

// File: doc/midi_voice_allocator.md
MIDI_VOICE_ALLOCATOR -- requirements
Module: midi_voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of voice slots; legal range 2..16.
REQ-002 Parameter MIDI_CH, default 0, MIDI channel accepted (0..15).
REQ-003 Parameter OMNI, default 0; when 1, channel nibble is ignored.
REQ-004 CLK  in  1  single system clock; all logic on rising edge.
REQ-005 RST  in  1  reset; synchronous, active-high.
REQ-006 MIDI_MSG  in  24  [23:16] status, [15:8] data1, [7:0] data2.
REQ-007 MIDI_MSG_RDY  in  1  one-cycle strobe qualifying MIDI_MSG.
REQ-008 VOICE_NOTE  out  8*NUM_VOICES  note number per voice; voice v at [8v+7:8v].
REQ-009 VOICE_VEL  out  8*NUM_VOICES  velocity per voice, same packing.
REQ-010 VOICE_GATE  out  NUM_VOICES  1 = voice held.
REQ-011 VOICE_TRIG  out  NUM_VOICES  one-cycle pulse when a voice is (re)assigned.
REQ-012 ACTIVE_COUNT  out  5  number of gated voices.

Function
REQ-013 Message accepted only when MIDI_MSG_RDY=1 and (OMNI=1 or status[3:0]=MIDI_CH); otherwise ignored.
REQ-014 Data bytes are masked to 7 bits before use; bit 7 of data1/data2 never appears on outputs.
REQ-015 Note-on = status[7:4]=9 with data2!=0; note-off = status[7:4]=8, or status[7:4]=9 with data2=0.
REQ-016 All-notes-off = status[7:4]=B with data1=123; clears every gate bit, NOTE/VEL unchanged.
REQ-017 All outputs registered; effect of an accepted message is visible exactly 1 cycle after the RDY cycle.
REQ-018 Note-on, note already gated on voice v: retrigger v -- VEL updated, gate stays 1, TRIG[v] pulses, no other voice changes.
REQ-019 Note-on, note not gated, at least one free voice (gate=0): lowest-index free voice assigned.
REQ-020 Note-on, all voices gated: the oldest voice (rank NUM_VOICES-1) is stolen; NOTE/VEL overwritten, TRIG pulses, gate stays 1.
REQ-021 Age ranks: each voice holds a unique rank 0..NUM_VOICES-1; on assignment or retrigger the voice gets rank 0 and every voice with a smaller old rank increments by 1.
REQ-022 Note-off: every gated voice whose NOTE matches clears its gate; NOTE/VEL/rank unchanged; no TRIG; note-off for an unheld note has no effect.
REQ-023 VOICE_TRIG is high for exactly one cycle per assignment; at most one TRIG bit high in any cycle.
REQ-024 ACTIVE_COUNT equals popcount(VOICE_GATE) in the same cycle.
REQ-025 Back-to-back RDY on consecutive cycles: each message processed in order with no loss.
REQ-026 Non-note, non-all-notes-off messages (other CC, pitch bend, program change) ignored.

Reset
REQ-027 While RST=1: VOICE_NOTE=0, VOICE_VEL=0, VOICE_GATE=0, VOICE_TRIG=0, ACTIVE_COUNT=0, rank[v]=v.
REQ-028 RST takes priority over a concurrent MIDI_MSG_RDY; that message is dropped.
REQ-029 A RST during held notes clears all state in one cycle; the first message after RST deasserts is processed normally.

Structure
REQ-030 Package midi_pkg holds status-nibble constants (NOTE_OFF=8, NOTE_ON=9, CTRL=B), CC_ALL_NOTES_OFF=123, and the 7-bit masking helper.
REQ-031 One sub-module, voice_select: combinational; from gates, ranks, notes and the incoming note produces the match index, lowest free index and oldest index with valid flags.

Verification
REQ-032 NUM_VOICES=4: note-on 60/100, 64/90, 67/80 -> voices 0,1,2 gated with those notes, TRIG pulses 0,1,2, ACTIVE_COUNT=3.
REQ-033 Five note-ons 60,62,64,65,67 -> 67 steals voice 0 (oldest); VOICE_NOTE={65,64,62,67} for v3..v0, ACTIVE_COUNT=4.
REQ-034 Hold 60 on v0; send 0x90 60 0 -> gate[0]=0, NOTE[0]=60 kept, no TRIG; next note-on 72 lands on v0.
REQ-035 Hold 60 on v0, send note-on 60/30 -> v0 retriggered, VEL[0]=30, TRIG[0] pulse, ACTIVE_COUNT=1.
REQ-036 MIDI_CH=0: note-on 0x91 60 100 ignored; 0xB0 123 0 with three voices held -> all gates 0; RST asserted with RDY=1 -> all outputs 0, ranks 0..3.
